// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-client arbiter for a dual-port memory; per-client request/grant/read-return ports (*_i[c]), memory-side EN/addr/data lines, RAW stall on same-address write/read
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             EN_wr_i,
  input  logic [1:0][ADDR_W-1:0] wr_addr_i,
  input  logic [1:0][DATA_W-1:0] wr_val_i,
  output logic [1:0]             RDY_wr_i,
  input  logic [1:0]             EN_rd_i,
  input  logic [1:0][ADDR_W-1:0] rd_addr_i,
  output logic [1:0]             RDY_rd_i,
  output logic [1:0]             VALID_rd_i,
  output logic [1:0][DATA_W-1:0] rd_data_i,
  output logic                   EN_writeMem,
  output logic [ADDR_W-1:0]      writeMem_addr,
  output logic [DATA_W-1:0]      writeMem_val,
  output logic                   EN_readMem,
  output logic [ADDR_W-1:0]      readMem_addr,
  input  logic [DATA_W-1:0]      readMem_val
);
  logic wr_prio_q, wr_prio_d, rd_prio_q, rd_prio_d;
  logic wr_sel, rd_sel, wr_go, rd_req, rd_go, raw;
  logic [RD_LAT-1:0] tag_v_q, tag_o_q;
  always_comb begin
    wr_sel = &EN_wr_i ? wr_prio_q : EN_wr_i[1];
    rd_sel = &EN_rd_i ? rd_prio_q : EN_rd_i[1];
    wr_go = ~rst & |EN_wr_i;
    rd_req = ~rst & |EN_rd_i;
    raw = wr_go & rd_req & (rd_addr_i[rd_sel] == wr_addr_i[wr_sel]);
    rd_go = rd_req & ~raw;
    wr_prio_d = wr_go ? ~wr_sel : wr_prio_q;
    rd_prio_d = rd_go ? ~rd_sel : rd_prio_q;
    RDY_wr_i = wr_go ? 2'b01 << wr_sel : 2'b00;
    RDY_rd_i = rd_go ? 2'b01 << rd_sel : 2'b00;
    EN_writeMem = wr_go;
    writeMem_addr = wr_go ? wr_addr_i[wr_sel] : '0;
    writeMem_val = wr_go ? wr_val_i[wr_sel] : '0;
    EN_readMem = rd_go;
    readMem_addr = rd_go ? rd_addr_i[rd_sel] : '0;
    VALID_rd_i = ~rst & tag_v_q[RD_LAT-1] ? 2'b01 << tag_o_q[RD_LAT-1] : 2'b00;
    rd_data_i[0] = VALID_rd_i[0] ? readMem_val : '0;
    rd_data_i[1] = VALID_rd_i[1] ? readMem_val : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prio_q <= 1'b0;
      rd_prio_q <= 1'b0;
      tag_v_q <= '0;
      tag_o_q <= '0;
    end else begin
      wr_prio_q <= wr_prio_d;
      rd_prio_q <= rd_prio_d;
      tag_v_q[0] <= rd_go;
      tag_o_q[0] <= rd_sel;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v_q[k] <= tag_v_q[k-1];
        tag_o_q[k] <= tag_o_q[k-1];
      end
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter for the dual-port 64x16 result memory (`memory_wrapper_2port` / `registerArray`). It shares the single write port (port B) and the single read port (port A) between two requesters, for example the multiplier and a second producer/consumer, with independent round-robin on each port. It enforces read-after-write ordering on address collisions and routes read data back to the client that issued the read, with a VALID strobe. It sits between the clients and the memory and drives the memory's EN/addr/data lines exactly as the multiplier does today.

## Interface
Parameters:
- ADDR_W, 6, memory address width
- DATA_W, 16, memory data width
- RD_LAT, 1, cycles from a granted read (EN_readMem high at the edge) to valid readMem_val

Ports (i = 0, 1; one set per client):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- EN_wr_i  in  1  client i write request (level, held until RDY_wr_i)
- wr_addr_i  in  ADDR_W  write address
- wr_val_i  in  DATA_W  write data
- RDY_wr_i  out  1  write granted this cycle (combinational)
- EN_rd_i  in  1  client i read request (level, held until RDY_rd_i)
- rd_addr_i  in  ADDR_W  read address
- RDY_rd_i  out  1  read granted this cycle (combinational)
- VALID_rd_i  out  1  rd_data_i carries client i's read result
- rd_data_i  out  DATA_W  readMem_val when VALID_rd_i, else 0
- EN_writeMem  out  1  memory write enable (memory cenB = ~EN_writeMem)
- writeMem_addr  out  ADDR_W  memory aB
- writeMem_val  out  DATA_W  memory d
- EN_readMem  out  1  memory read enable (memory cenA = ~EN_readMem)
- readMem_addr  out  ADDR_W  memory aA
- readMem_val  in  DATA_W  memory q

## Operation
- Each port has its own 1-bit priority pointer, wr_prio and rd_prio. Reset value is 0, so client 0 has priority.
- Port grant per cycle:
  - Only one client requesting: that client is granted.
  - Both requesting: the client named by the pointer is granted.
  - After any grant, the pointer moves to the other client. Under continuous contention, grants strictly alternate.
- Memory outputs follow the granted client combinationally.
  - With no grant: EN_* = 0, addr = 0, data = 0.
- RAW hazard:
  - Condition: a write grant and a read grant fall in the same cycle with readMem_addr == writeMem_addr.
  - The write proceeds. The read grant is suppressed: RDY_rd_i = 0, EN_readMem = 0, and rd_prio is not updated.
  - The read is re-arbitrated next cycle, so it returns the newly written data.
- Read routing:
  - An RD_LAT-deep shift register of {valid, owner} is loaded on each granted read.
  - At its output, VALID_rd_owner = 1 and rd_data_owner = readMem_val. The other client sees VALID = 0 and data = 0.
- Reads can be issued every cycle. Up to RD_LAT reads are in flight, each tagged independently.
- There are no internal data buffers. Clients hold their request until granted.

## Timing
- Reset (rst = 1 at an edge):
  - Pointers return to 0 and the tag pipeline clears.
  - While rst is high, all RDY_*, VALID_*, and EN_* outputs are 0, and all addr/data outputs are 0. Requests are ignored.
- Grant latency: 0 cycles. RDY is asserted in the same cycle as EN when the port is won.
- Worst-case wait under contention: 1 cycle per port. A RAW stall adds 1 more cycle.
- Read latency: VALID_rd_i rises exactly RD_LAT cycles after the cycle in which RDY_rd_i = 1.
- Reset mid-operation: in-flight reads are discarded. No VALID is produced for a read granted before or during rst.
- Same client, write and read in the same cycle: both ports are arbitrated independently. The RAW rule still applies.
- Addresses are used unmodified. There is no wrap or bounds logic; ADDR_W bits cover the full memory.

## Test plan
- **Reset:** drive arbitrary requests with rst = 1 for 3 cycles → every output is 0. First contended grant after release goes to client 0.
- **Single client write/read:**
  - Client 0 writes 0x0005 to addr 3. Next cycle, client 0 reads addr 3.
  - Required: RDY_rd_0 = 1, then VALID_rd_0 = 1 with rd_data_0 = 0x0005 one cycle later. VALID_rd_1 stays 0.
- **Write contention:** both clients hold EN_wr for 4 cycles (addrs 10/20, data 0x0011/0x0022) → RDY_wr sequence is 0, 1, 0, 1, and writeMem_addr is 10, 20, 10, 20.
- **RAW hazard:**
  - In the same cycle, client 0 writes 0x0031 to addr 7 and client 1 reads addr 7.
  - Required: RDY_rd_1 = 0 that cycle and 1 the next. VALID_rd_1 follows with rd_data_1 = 0x0031.
- **Read routing:**
  - Memory preloaded with addr 1 = 0x0009 and addr 2 = 0x0010. Client 0 reads addr 1 and client 1 reads addr 2, both held.
  - Required: VALID_rd_0 with 0x0009, then VALID_rd_1 with 0x0010 on consecutive cycles.
- **Reset mid-read:** client 1 read is granted, then rst = 1 on the next edge → VALID_rd_1 never asserts and all outputs are 0.
